// File: rtl/hazard_stall_ctrl.sv
// Purpose: pipeline stall/flush control covering load-use bubbles, EX jump flushes and interrupt sequencing.
// Latency: outputs are combinational from registered state plus current inputs; state advances one step per clk.
// Backpressure: holds PC and IF/ID while stalled; int_req is held until the int_ack pulse. Optional macro HAZ_PERF_CNT_EN adds stall/flush counters.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int INT_DRAIN_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [2:0] ex_rdst,
  input  logic [2:0] id_rsrc,
  input  logic [2:0] id_rdst,
  input  logic       id_uses_rsrc,
  input  logic       id_uses_rdst,
  input  logic       ex_is_jmp,
  input  logic       int_req,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       int_inject,
  output logic [1:0] int_phase,
  output logic       int_ack
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LD_STALL  = 3'd1,
    S_INT_DRAIN = 3'd2,
    S_INT_PC    = 3'd3,
    S_INT_FLAGS = 3'd4,
    S_INT_VEC   = 3'd5
  } state_t;

  // With a single bubble the LD_STALL state is never entered, so its reload is unused.
  localparam logic [3:0] LD_RELOAD    = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
  localparam logic [3:0] DRAIN_RELOAD = 4'(INT_DRAIN_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       hz;

  assign hz = ex_mem_read & ex_reg_write &
              ((id_uses_rsrc & (id_rsrc == ex_rdst)) | (id_uses_rdst & (id_rdst == ex_rdst)));

  // State and bubble/drain counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and outputs; jump beats interrupt beats load-use, reset forces everything low.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    id_ex_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    int_inject  = 1'b0;
    int_phase   = 2'b00;
    int_ack     = 1'b0;

    case (state)
      S_IDLE: begin
        if (ex_is_jmp) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (int_req) begin
          // The pending load (if any) finishes while fetch drains.
          state_nxt = S_INT_DRAIN;
          cnt_nxt   = DRAIN_RELOAD;
        end else if (hz) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_nxt = S_LD_STALL;
            cnt_nxt   = LD_RELOAD;
          end
        end
      end

      S_LD_STALL: begin
        if (ex_is_jmp) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_nxt   = S_IDLE;
          cnt_nxt     = 4'd0;
        end else begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt == 4'd0) begin
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end

      S_INT_DRAIN: begin
        if (ex_is_jmp) begin
          // A late jump refills the front end, so the drain restarts.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          cnt_nxt     = DRAIN_RELOAD;
        end else begin
          pc_stall    = 1'b1;
          if_id_flush = 1'b1;
          if (cnt == 4'd0) begin
            state_nxt = S_INT_PC;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end

      S_INT_PC: begin
        pc_stall    = ~ex_is_jmp;
        if_id_flush = 1'b1;
        id_ex_flush = ex_is_jmp;
        int_inject  = 1'b1;
        int_phase   = 2'b01;
        state_nxt   = S_INT_FLAGS;
      end

      S_INT_FLAGS: begin
        pc_stall    = ~ex_is_jmp;
        if_id_flush = 1'b1;
        id_ex_flush = ex_is_jmp;
        int_inject  = 1'b1;
        int_phase   = 2'b10;
        state_nxt   = S_INT_VEC;
      end

      S_INT_VEC: begin
        if_id_flush = ex_is_jmp;
        id_ex_flush = ex_is_jmp;
        int_phase   = 2'b11;
        int_ack     = 1'b1;
        state_nxt   = S_IDLE;
        cnt_nxt     = 4'd0;
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase

    if (reset) begin
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      id_ex_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      int_inject  = 1'b0;
      int_phase   = 2'b00;
      int_ack     = 1'b0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating counts of stalled cycles and flushing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (pc_stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if ((if_id_flush || id_ex_flush) && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two configurations driven by shared stimulus.
// Directed cases pin literal expectations; a step-count model checks every cycle.
// Output vector order: pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, int_inject, int_phase[1:0], int_ack.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_mem_read, ex_reg_write, id_uses_rsrc, id_uses_rdst, ex_is_jmp, int_req;
  logic [2:0] ex_rdst, id_rsrc, id_rdst;

  logic       a_pcs, a_ifs, a_ies, a_iff, a_ief, a_inj, a_ack;
  logic [1:0] a_ph;
  logic       b_pcs, b_ifs, b_ies, b_iff, b_ief, b_inj, b_ack;
  logic [1:0] b_ph;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
`endif

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  // Model state: load bubbles still owed, and position within an interrupt sequence (0 = none).
  int a_ld = 0, a_step = 0, b_ld = 0, b_step = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .INT_DRAIN_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rdst(ex_rdst), .id_rsrc(id_rsrc), .id_rdst(id_rdst), .id_uses_rsrc(id_uses_rsrc),
    .id_uses_rdst(id_uses_rdst), .ex_is_jmp(ex_is_jmp), .int_req(int_req),
    .pc_stall(a_pcs), .if_id_stall(a_ifs), .id_ex_stall(a_ies), .if_id_flush(a_iff),
    .id_ex_flush(a_ief), .int_inject(a_inj), .int_phase(a_ph), .int_ack(a_ack)
`ifdef HAZ_PERF_CNT_EN
    , .stall_count(a_sc), .flush_count(a_fc)
`endif
  );

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .INT_DRAIN_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rdst(ex_rdst), .id_rsrc(id_rsrc), .id_rdst(id_rdst), .id_uses_rsrc(id_uses_rsrc),
    .id_uses_rdst(id_uses_rdst), .ex_is_jmp(ex_is_jmp), .int_req(int_req),
    .pc_stall(b_pcs), .if_id_stall(b_ifs), .id_ex_stall(b_ies), .if_id_flush(b_iff),
    .id_ex_flush(b_ief), .int_inject(b_inj), .int_phase(b_ph), .int_ack(b_ack)
`ifdef HAZ_PERF_CNT_EN
    , .stall_count(b_sc), .flush_count(b_fc)
`endif
  );

  wire [8:0] out_a = {a_pcs, a_ifs, a_ies, a_iff, a_ief, a_inj, a_ph, a_ack};
  wire [8:0] out_b = {b_pcs, b_ifs, b_ies, b_iff, b_ief, b_inj, b_ph, b_ack};

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  function automatic bit hazard();
    bit same_src, same_dst;
    same_src = id_uses_rsrc && (id_rsrc == ex_rdst);
    same_dst = id_uses_rdst && (id_rdst == ex_rdst);
    return ex_mem_read && ex_reg_write && (same_src || same_dst);
  endfunction

  // Expected outputs for one cycle plus the model's next state.
  // Interrupt positions 1..D are drain cycles, then D+1 push PC, D+2 push flags, D+3 vector.
  task automatic model(input int L, input int D, input int ld, input int step,
                       output int ld_n, output int step_n, output logic [8:0] exp);
    logic ps, fs, es, ff, ef, inj, ack;
    logic [1:0] ph;
    int p;
    ps = 0; fs = 0; es = 0; ff = 0; ef = 0; inj = 0; ack = 0; ph = 2'd0;
    ld_n = ld;
    step_n = step;
    if (reset) begin
      ld_n = 0;
      step_n = 0;
    end else if (step > 0) begin
      p = step - D;
      if (p <= 0) begin
        ps = 1; ff = 1;
      end else if (p < 3) begin
        ps = 1; ff = 1; inj = 1; ph = 2'(p);
      end else begin
        ph = 2'd3; ack = 1;
      end
      step_n = (p == 3) ? 0 : step + 1;
      if (ex_is_jmp) begin
        ps = 0; ff = 1; ef = 1;
        if (p <= 0) step_n = 1;
      end
    end else if (ld > 0) begin
      if (ex_is_jmp) begin
        ff = 1; ef = 1; ld_n = 0;
      end else begin
        ps = 1; fs = 1; ef = 1; ld_n = ld - 1;
      end
    end else begin
      if (ex_is_jmp) begin
        ff = 1; ef = 1;
      end else if (int_req) begin
        step_n = 1;
      end else if (hazard()) begin
        ps = 1; fs = 1; ef = 1; ld_n = L - 1;
      end
    end
    exp = {ps, fs, es, ff, ef, inj, ph, ack};
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [8:0] ea, eb;
    int nl, ns;
    if (run_chk) begin
      model(1, 2, a_ld, a_step, nl, ns, ea);
      a_ld = nl; a_step = ns;
      check("model_a", out_a, ea);
      model(3, 1, b_ld, b_step, nl, ns, eb);
      b_ld = nl; b_step = ns;
      check("model_b", out_b, eb);
    end
  end

  task automatic clr_in();
    ex_mem_read = 0; ex_reg_write = 0; ex_rdst = 0; id_rsrc = 0; id_rdst = 0;
    id_uses_rsrc = 0; id_uses_rdst = 0; ex_is_jmp = 0;
  endtask

  task automatic set_hazard();
    ex_mem_read = 1; ex_reg_write = 1; ex_rdst = 3'd3; id_rsrc = 3'd3; id_uses_rsrc = 1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [8:0] STALL = 9'b110010000;
  localparam logic [8:0] JFLSH = 9'b000110000;
  localparam logic [8:0] DRAIN = 9'b100100000;

  initial begin
    logic [8:0] int_exp [6];
    int_exp[0] = 9'b000000000;
    int_exp[1] = DRAIN;
    int_exp[2] = DRAIN;
    int_exp[3] = 9'b100101010;
    int_exp[4] = 9'b100101100;
    int_exp[5] = 9'b000000111;

    clr_in();
    reset = 1;
    set_hazard();
    int_req = 1;
    run_chk = 1;
    @(negedge clk);
    check("reset_out_a", out_a, 9'd0);
    check("reset_out_b", out_b, 9'd0);
    next_cyc();
    reset = 0;
    int_req = 0;

    // Load-use: a stalls once, b stalls three times.
    set_hazard();
    @(negedge clk);
    check("lu_a_c0", out_a, STALL);
    check("mb_b_c0", out_b, STALL);
    next_cyc();
    clr_in();
    @(negedge clk);
    check("lu_a_c1", out_a, 9'd0);
    check("mb_b_c1", out_b, STALL);
    next_cyc();
    @(negedge clk);
    check("mb_b_c2", out_b, STALL);
    next_cyc();
    @(negedge clk);
    check("mb_b_c3", out_b, 9'd0);

    // Matching register numbers without a read: no hazard.
    next_cyc();
    ex_mem_read = 1; ex_reg_write = 1; ex_rdst = 3'd3; id_rdst = 3'd3; id_rsrc = 3'd3;
    @(negedge clk);
    check("nofalse_a", out_a, 9'd0);
    check("nofalse_b", out_b, 9'd0);

    // Jump while b is in LD_STALL.
    next_cyc();
    clr_in();
    set_hazard();
    @(negedge clk);
    check("jmp_b_hz", out_b, STALL);
    next_cyc();
    clr_in();
    ex_is_jmp = 1;
    @(negedge clk);
    check("jmp_b_flush", out_b, JFLSH);
    next_cyc();
    clr_in();
    @(negedge clk);
    check("jmp_b_idle", out_b, 9'd0);

    // Interrupt sequence on a; request dropped after the ack.
    next_cyc();
    int_req = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("int_a_c%0d", i), out_a, int_exp[i]);
      next_cyc();
    end
    int_req = 0;
    @(negedge clk);
    check("int_a_done", out_a, 9'd0);
    repeat (5) next_cyc();

    // Reset during INT_FLAGS aborts the sequence.
    int_req = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rint_a_c%0d", i), out_a, int_exp[i]);
      next_cyc();
    end
    reset = 1;
    @(negedge clk);
    check("rst_mid_a", out_a, 9'd0);
    next_cyc();
    reset = 0;
    int_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst_noack_a%0d", i), out_a, 9'd0);
      next_cyc();
    end

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      ex_mem_read  = $urandom_range(0, 1) == 1;
      ex_reg_write = $urandom_range(0, 3) != 0;
      ex_rdst      = 3'($urandom_range(0, 7));
      id_rsrc      = ($urandom_range(0, 1) == 1) ? ex_rdst : 3'($urandom_range(0, 7));
      id_rdst      = ($urandom_range(0, 2) == 0) ? ex_rdst : 3'($urandom_range(0, 7));
      id_uses_rsrc = $urandom_range(0, 1) == 1;
      id_uses_rdst = $urandom_range(0, 1) == 1;
      ex_is_jmp    = ($urandom_range(0, 9) == 0);
      if (!int_req) int_req = ($urandom_range(0, 19) == 0);
      else if (a_ack || $urandom_range(0, 11) == 0) int_req = 0;
      next_cyc();
    end

    run_chk = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central pipeline control unit that produces the stall and flush signals consumed by the PC register and the IF/ID and ID/EX buffers. It detects load-use hazards and holds fetch/decode for a configurable number of cycles. It flushes the front end on taken jumps resolved in EX. It also sequences interrupts: drain, push PC, push flags, then a vector load.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15)
INT_DRAIN_CYCLES, 2, cycles fetch is frozen before interrupt pushes begin (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ex_mem_read  in  1  instruction in EX reads memory (ID/EX mem_read_out)
ex_reg_write  in  1  instruction in EX writes a register (reglow_write_out | reghigh_write_out)
ex_rdst  in  3  destination register of instruction in EX
id_rsrc  in  3  source register of instruction in ID
id_rdst  in  3  Rdst register read by instruction in ID
id_uses_rsrc  in  1  ID instruction reads id_rsrc
id_uses_rdst  in  1  ID instruction reads id_rdst
ex_is_jmp  in  1  taken jump resolved in EX this cycle
int_req  in  1  level interrupt request, held until int_ack
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
id_ex_stall  out  1  hold ID/EX
if_id_flush  out  1  clear IF/ID
id_ex_flush  out  1  clear ID/EX, inserting a bubble
int_inject  out  1  decode injects an interrupt micro-op
int_phase  out  2  00 none, 01 push PC, 10 push flags, 11 load vector
int_ack  out  1  one-cycle pulse on vector load

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). On a clk edge with reset=1, state goes to IDLE and counters go to 0. While reset=1, all outputs are forced to 0.
- Outputs are combinational from the registered state plus the current inputs.
- Hazard term: hz = ex_mem_read & ex_reg_write & ((id_uses_rsrc & id_rsrc==ex_rdst) | (id_uses_rdst & id_rdst==ex_rdst)).
- States: IDLE, LD_STALL, INT_DRAIN, INT_PC, INT_FLAGS, INT_VEC. Counter cnt is 4 bits.
- Priority within a cycle: reset > ex_is_jmp > interrupt > load-use.
- Jump rule (any state):
  - ex_is_jmp=1 gives if_id_flush=1 and id_ex_flush=1 that cycle, with no stall.
  - From IDLE or LD_STALL, the next state is IDLE.
  - In INT_DRAIN, cnt is reloaded to INT_DRAIN_CYCLES-1 and the state stays INT_DRAIN.
  - In INT_PC, INT_FLAGS and INT_VEC, the jump flush still applies and the sequence continues.
- IDLE:
  - int_req=1 (no jump) moves to INT_DRAIN with cnt=INT_DRAIN_CYCLES-1. No stall in the transition cycle.
  - Otherwise hz=1 gives pc_stall=1, if_id_stall=1, id_ex_flush=1 that cycle.
  - If LOAD_STALL_CYCLES>1, go to LD_STALL with cnt=LOAD_STALL_CYCLES-2.
  - int_req and hz in the same cycle: the interrupt wins and the load completes during the drain.
- LD_STALL:
  - pc_stall=1, if_id_stall=1, id_ex_flush=1.
  - cnt==0 moves to IDLE; otherwise cnt decrements.
  - int_req is ignored until back in IDLE.
- INT_DRAIN:
  - pc_stall=1, if_id_flush=1.
  - cnt==0 moves to INT_PC; otherwise cnt decrements.
- INT_PC: pc_stall=1, if_id_flush=1, int_inject=1, int_phase=01; next state INT_FLAGS.
- INT_FLAGS: same stall/flush, int_inject=1, int_phase=10; next state INT_VEC.
- INT_VEC: int_phase=11, int_ack=1, no stall (PC loads the vector); next state IDLE.
- id_ex_stall is 0 in all states (reserved for future multi-cycle EX).
- int_req must drop the cycle after int_ack. If it is still high in IDLE, a new sequence starts.
- Reset asserted mid-sequence aborts it; int_ack is not issued.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs stall_count (16) and flush_count (16), both saturating at 0xFFFF and cleared by reset.
  - stall_count increments on every cycle with pc_stall=1.
  - flush_count increments on every cycle with if_id_flush|id_ex_flush=1.
- Undefined: these ports and counters do not exist.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rdst=3, id_rsrc=3, id_uses_rsrc=1, LOAD_STALL_CYCLES=1 -> exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1, then 0.
- Multi-bubble: LOAD_STALL_CYCLES=3, hazard held one cycle -> 3 consecutive stall cycles, state back in IDLE after.
- No false hazard: ex_rdst=3, id_rdst=3, id_uses_rdst=0, id_uses_rsrc=0 -> all outputs 0.
- Jump: ex_is_jmp=1 during LD_STALL -> if_id_flush=id_ex_flush=1, pc_stall=0, next cycle IDLE.
- Interrupt: int_req=1 in IDLE, INT_DRAIN_CYCLES=2 -> 2 drain cycles (pc_stall=1, if_id_flush=1), int_phase 01 then 10, then 11 with one int_ack pulse exactly 5 cycles after request sampling.
- Reset mid-interrupt: reset=1 during INT_FLAGS -> outputs 0 that cycle, IDLE afterwards, no int_ack.
